// File: rtl/countdown_sequencer.sv
// -----------------------------------------------------------------------------
// countdown_sequencer
//
// Drives an external down-counter through R+1 rounds. Each round loads the
// counter with L, then decrements it until the counter reports co (value==1).
// All counter activity is qualified by clk_en, a tick strobe produced by an
// internal prescaler that fires once every P+1 clock cycles.
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst        in   asynchronous active-low reset
//   start      in   begin a sequence (honoured only in IDLE)
//   abort      in   terminate the running sequence (LOAD/COUNT)
//   load_val   in   [3:0] per-round count value L, sampled on accepted start
//   rounds     in   [2:0] number of rounds minus one (R), sampled on start
//   prescale   in   [3:0] tick divider P, sampled on accepted start
//   co         in   counter terminal flag (counter value == 1)
//   pin        out  [3:0] load value for the counter (latched L)
//   ld         out  counter load enable
//   cen        out  counter count enable
//   clk_en     out  one-cycle tick strobe qualifying counter updates
//   rst_cu     out  counter synchronous clear
//   busy       out  high in every non-IDLE state
//   done       out  one-cycle pulse on normal completion
//   aborted    out  one-cycle pulse on abort completion
//   err        out  one-cycle pulse on a rejected start (load_val == 0)
//   round_cnt  out  [2:0] 0-based index of the current round
// -----------------------------------------------------------------------------
module countdown_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] load_val,
    input  logic [2:0] rounds,
    input  logic [3:0] prescale,
    input  logic       co,
    output logic [3:0] pin,
    output logic       ld,
    output logic       cen,
    output logic       clk_en,
    output logic       rst_cu,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       err,
    output logic [2:0] round_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COUNT = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    state_t     r_state;
    logic [3:0] r_presc;
    logic [3:0] r_l;
    logic [2:0] r_r;
    logic [3:0] r_p;
    logic [2:0] r_round;

    logic       r_ld;
    logic       r_cen;
    logic       r_clk_en;
    logic       r_rst_cu;
    logic       r_busy;
    logic       r_done;
    logic       r_aborted;
    logic       r_err;

    state_t     w_next_state;
    logic       w_accept;
    logic       w_reject;
    logic       w_round_inc;
    logic [3:0] w_next_presc;
    logic [3:0] w_next_p;

    // -------------------------------------------------------------------------
    // Next-state and prescaler look-ahead. The output flops below are loaded
    // from these next values so every output is a true register yet lines up
    // with the state it describes.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_round_inc  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (load_val != 4'd0) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_LOAD;
                    end else begin
                        w_reject     = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // Abort wins over a coincident tick.
                if (abort) begin
                    w_next_state = ST_ABORT;
                end else if (r_clk_en) begin
                    w_next_state = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    w_next_state = ST_ABORT;
                end else if (r_clk_en && co) begin
                    if (r_round == r_r) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_round_inc  = 1'b1;
                        w_next_state = ST_LOAD;
                    end
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_ABORT: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase

        w_next_p = w_accept ? prescale : r_p;

        // Prescaler restarts only on a fresh start; between rounds it keeps
        // running so the round boundary does not stretch the tick period.
        if (w_accept) begin
            w_next_presc = 4'd0;
        end else if (r_state == ST_IDLE) begin
            w_next_presc = r_presc;
        end else if (r_presc == r_p) begin
            w_next_presc = 4'd0;
        end else begin
            w_next_presc = r_presc + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State, prescaler, latched parameters and registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_presc   <= 4'd0;
            r_l       <= 4'd0;
            r_r       <= 3'd0;
            r_p       <= 4'd0;
            r_round   <= 3'd0;
            r_ld      <= 1'b0;
            r_cen     <= 1'b0;
            r_clk_en  <= 1'b0;
            r_rst_cu  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values from
            // before the edge, independent of statement order.
            r_state <= w_next_state;
            r_presc <= w_next_presc;

            if (w_accept) begin
                r_l     <= load_val;
                r_r     <= rounds;
                r_p     <= prescale;
                r_round <= 3'd0;
            end else if (w_round_inc) begin
                r_round <= r_round + 3'd1;
            end

            r_ld      <= (w_next_state == ST_LOAD);
            r_cen     <= (w_next_state == ST_COUNT);
            r_clk_en  <= ((w_next_state == ST_LOAD) || (w_next_state == ST_COUNT))
                         && (w_next_presc == w_next_p);
            r_rst_cu  <= (w_next_state == ST_ABORT);
            r_aborted <= (w_next_state == ST_ABORT);
            r_done    <= (w_next_state == ST_DONE);
            r_busy    <= (w_next_state != ST_IDLE);
            r_err     <= w_reject;
        end
    end

    assign pin       = r_l;
    assign ld        = r_ld;
    assign cen       = r_cen;
    assign clk_en    = r_clk_en;
    assign rst_cu    = r_rst_cu;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign err       = r_err;
    assign round_cnt = r_round;

endmodule

// File: tb/tb_countdown_sequencer.sv
// -----------------------------------------------------------------------------
// tb_countdown_sequencer
//
// Directed bench for countdown_sequencer. A small behavioural down-counter
// closes the loop (pin/ld/cen/clk_en/rst_cu in, co out). Outputs are sampled
// on the falling clock edge; inputs are changed right after sampling.
// Cycle k means the cycle following the k-th rising edge after start was set.
// Flag vector order: {busy, ld, cen, clk_en, rst_cu, done, aborted, err}.
// -----------------------------------------------------------------------------
module tb_countdown_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] load_val;
    logic [2:0] rounds;
    logic [3:0] prescale;
    logic       co;
    logic [3:0] pin;
    logic       ld;
    logic       cen;
    logic       clk_en;
    logic       rst_cu;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       err;
    logic [2:0] round_cnt;

    logic [3:0] cnt;
    logic [7:0] w_flags;

    int n_vec;
    int n_err;

    countdown_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .load_val  (load_val),
        .rounds    (rounds),
        .prescale  (prescale),
        .co        (co),
        .pin       (pin),
        .ld        (ld),
        .cen       (cen),
        .clk_en    (clk_en),
        .rst_cu    (rst_cu),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .err       (err),
        .round_cnt (round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural external counter.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (rst_cu) begin
            cnt <= 4'd0;
        end else if (clk_en && ld) begin
            cnt <= pin;
        end else if (clk_en && cen) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign co      = (cnt == 4'd1);
    assign w_flags = {busy, ld, cen, clk_en, rst_cu, done, aborted, err};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic begin_seq(input logic [3:0] l, input logic [2:0] r, input logic [3:0] p);
        load_val = l;
        rounds   = r;
        prescale = p;
        start    = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_f;
        int         done_cycle;
        int         ticks;

        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        load_val = 4'd0;
        rounds   = 3'd0;
        prescale = 4'd0;

        repeat (2) @(negedge clk);
        check("reset_flags", {24'd0, w_flags}, 32'h00);
        check("reset_round", {29'd0, round_cnt}, 32'd0);
        check("reset_pin",   {28'd0, pin}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ---- P=0, L=3, R=0; abort raised in DONE must be ignored ----------
        begin_seq(4'd3, 3'd0, 4'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            case (k)
                1:       exp_f = 8'b1101_0000;
                2, 3, 4: exp_f = 8'b1011_0000;
                5:       exp_f = 8'b1000_0100;
                default: exp_f = 8'b0000_0000;
            endcase
            check($sformatf("s1_c%0d", k), {24'd0, w_flags}, {24'd0, exp_f});
            if (k == 4) check("s1_co_c4", {31'd0, co}, 32'd1);
            if (k == 2) check("s1_pin",   {28'd0, pin}, 32'd3);
            if (k == 1) start = 1'b0;
            if (k == 5) abort = 1'b1;
            if (k == 6) abort = 1'b0;
        end

        // ---- P=2, L=2, R=1; inputs changed mid-sequence must not matter ---
        begin_seq(4'd2, 3'd1, 4'd2);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_f = {(k <= 19),
                     ((k >= 1 && k <= 3) || (k >= 10 && k <= 12)),
                     ((k >= 4 && k <= 9) || (k >= 13 && k <= 18)),
                     ((k % 3 == 0) && (k <= 18)),
                     1'b0, (k == 19), 1'b0, 1'b0};
            check($sformatf("s2_c%0d", k), {24'd0, w_flags}, {24'd0, exp_f});
            check($sformatf("s2_rnd_c%0d", k), {29'd0, round_cnt}, (k >= 10) ? 32'd1 : 32'd0);
            if (k == 5) check("s2_pin", {28'd0, pin}, 32'd2);
            if (k == 1) begin
                start    = 1'b0;
                load_val = 4'd9;
                rounds   = 3'd0;
                prescale = 4'd0;
            end
            if (k == 2) start = 1'b1;
            if (k == 4) start = 1'b0;
        end

        // ---- rejected start ------------------------------------------------
        begin_seq(4'd0, 3'd2, 4'd1);
        @(negedge clk);
        check("err_c1", {24'd0, w_flags}, 32'h01);
        start = 1'b0;
        @(negedge clk);
        check("err_c2", {24'd0, w_flags}, 32'h00);

        // ---- abort coincident with a COUNT tick ----------------------------
        begin_seq(4'd3, 3'd0, 4'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            case (k)
                1:       exp_f = 8'b1101_0000;
                2:       exp_f = 8'b1011_0000;
                3:       exp_f = 8'b1000_1010;
                default: exp_f = 8'b0000_0000;
            endcase
            check($sformatf("ab_c%0d", k), {24'd0, w_flags}, {24'd0, exp_f});
            if (k == 1) start = 1'b0;
            if (k == 2) abort = 1'b1;
            if (k == 3) abort = 1'b0;
        end
        check("ab_cnt_cleared", {28'd0, cnt}, 32'd0);

        // ---- asynchronous reset mid-COUNT, then a clean 4-round run --------
        begin_seq(4'd2, 3'd3, 4'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 8) begin
                check("rs_c8_flags", {24'd0, w_flags}, 32'b1101_0000);
                check("rs_c8_round", {29'd0, round_cnt}, 32'd1);
            end
        end
        check("rs_c10_flags", {24'd0, w_flags}, 32'b1011_0000);
        #2 rst = 1'b0;
        #1;
        check("rs_async_flags", {24'd0, w_flags}, 32'h00);
        check("rs_async_round", {29'd0, round_cnt}, 32'd0);
        check("rs_async_pin",   {28'd0, pin}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        begin_seq(4'd2, 3'd3, 4'd1);
        done_cycle = 0;
        ticks      = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (clk_en) ticks++;
            if (done) begin
                done_cycle = k;
                check("rs_done_round", {29'd0, round_cnt}, 32'd3);
                break;
            end
        end
        check("rs_done_cycle", done_cycle, 32'd25);
        check("rs_tick_total", ticks, 32'd12);

        // ---- start held high across back-to-back sequences -----------------
        @(negedge clk);
        begin_seq(4'd1, 3'd0, 4'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            case (k)
                1, 5:    exp_f = 8'b1101_0000;
                2, 6:    exp_f = 8'b1011_0000;
                3, 7:    exp_f = 8'b1000_0100;
                default: exp_f = 8'b0000_0000;
            endcase
            check($sformatf("hs_c%0d", k), {24'd0, w_flags}, {24'd0, exp_f});
            if (k == 5) start = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
